// File: rtl/link_pkg.sv
// Shared types and default constants for the UART framing link.
package link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_TX_START,
    ST_TX_WAIT,
    ST_TX_HOLD
  } link_state_t;

  localparam int unsigned REPEAT_BYTE = 0;
  localparam int unsigned REPEAT_WORD = 1;

  localparam int unsigned DEF_RX_BYTES       = 76;
  localparam int unsigned DEF_TX_WORD_BYTES  = 4;
  localparam int unsigned DEF_TX_REPEAT      = 4;
  localparam int unsigned DEF_REPEAT_MODE    = REPEAT_BYTE;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 200_000;

endpackage

// File: rtl/tx_byte_seq.sv
// Maps an outbound sequence index to the word byte it transmits.
module tx_byte_seq
  import link_pkg::*;
#(
  parameter int unsigned WORD_BYTES = DEF_TX_WORD_BYTES,
  parameter int unsigned REPEAT     = DEF_TX_REPEAT,
  parameter int unsigned MODE       = DEF_REPEAT_MODE,
  parameter int unsigned IDX_W      = 5
) (
  input  logic [WORD_BYTES*8-1:0] word_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic [7:0]              byte_o
);

  always_comb begin
    int unsigned sel;
    sel = 0;
    if (MODE == REPEAT_WORD) begin
      sel = 32'(idx_i) % WORD_BYTES;
    end else begin
      sel = 32'(idx_i) / REPEAT;
    end
    byte_o = word_i[8*sel +: 8];
  end

endmodule

// File: rtl/uart_frame_link.sv
// Byte-stream framing engine: assembles inbound frames from uart_rx bytes and
// serialises an outbound word to uart_tx with configurable redundancy.
module uart_frame_link
  import link_pkg::*;
#(
  parameter int unsigned RX_BYTES       = DEF_RX_BYTES,
  parameter int unsigned TX_WORD_BYTES  = DEF_TX_WORD_BYTES,
  parameter int unsigned TX_REPEAT      = DEF_TX_REPEAT,
  parameter int unsigned REPEAT_MODE    = DEF_REPEAT_MODE,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       rx_enable,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  output logic [RX_BYTES*8-1:0]      frame_o,
  output logic                       frame_valid,
  output logic                       frame_done,
  output logic                       frame_abort,
  input  logic                       tx_enable,
  input  logic [TX_WORD_BYTES*8-1:0] tx_word,
  output logic                       tx_dv,
  output logic [7:0]                 tx_byte,
  input  logic                       tx_done,
  output logic                       send_done
);

  localparam int unsigned N     = TX_WORD_BYTES * TX_REPEAT;
  localparam int unsigned RXC_W = $clog2(RX_BYTES + 1);
  localparam int unsigned IDX_W = $clog2(N + 1);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [RXC_W-1:0] RX_LAST  = RXC_W'(RX_BYTES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  link_state_t                state_q, state_d;
  logic [RXC_W-1:0]           rx_count_q, rx_count_d;
  logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0]           tx_idx_q, tx_idx_d;
  logic [TX_WORD_BYTES*8-1:0] word_q, word_d;
  logic [RX_BYTES*8-1:0]      shadow_q, shadow_d;
  logic [RX_BYTES*8-1:0]      frame_q, frame_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       frame_done_q, frame_done_d;
  logic                       frame_abort_q, frame_abort_d;
  logic                       tx_dv_q, tx_dv_d;
  logic [7:0]                 tx_byte_q, tx_byte_d;
  logic                       send_done_q, send_done_d;
  logic [7:0]                 seq_byte;

  tx_byte_seq #(
    .WORD_BYTES (TX_WORD_BYTES),
    .REPEAT     (TX_REPEAT),
    .MODE       (REPEAT_MODE),
    .IDX_W      (IDX_W)
  ) u_seq (
    .word_i (word_q),
    .idx_i  (tx_idx_q),
    .byte_o (seq_byte)
  );

  always_comb begin
    int unsigned wr_idx;
    wr_idx        = 32'(rx_count_q);
    state_d       = state_q;
    rx_count_d    = rx_count_q;
    to_cnt_d      = to_cnt_q;
    tx_idx_d      = tx_idx_q;
    word_d        = word_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    tx_dv_d       = 1'b0;
    tx_byte_d     = tx_byte_q;
    send_done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_enable) begin
          state_d    = ST_RX;
          rx_count_d = '0;
          to_cnt_d   = '0;
        end else if (tx_enable) begin
          state_d  = ST_TX_START;
          word_d   = tx_word;
          tx_idx_d = '0;
        end
      end
      ST_RX: begin
        if (!rx_enable) begin
          state_d    = ST_IDLE;
          rx_count_d = '0;
          to_cnt_d   = '0;
        end else if (rx_valid) begin
          // A byte in the expiry cycle wins over the timeout.
          shadow_d[8*wr_idx +: 8] = rx_byte;
          to_cnt_d                = '0;
          if (rx_count_q == RX_LAST) begin
            frame_d       = shadow_d;
            rx_count_d    = '0;
            frame_done_d  = 1'b1;
            frame_valid_d = 1'b1;
          end else begin
            rx_count_d = rx_count_q + 1'b1;
          end
        end else if (TIMEOUT_CYCLES != 0 && rx_count_q != '0) begin
          if (to_cnt_q == TO_LAST) begin
            rx_count_d    = '0;
            to_cnt_d      = '0;
            frame_abort_d = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end
      ST_TX_START: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = seq_byte;
        state_d   = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (tx_done) begin
          if (tx_idx_q != IDX_LAST) begin
            tx_idx_d = tx_idx_q + 1'b1;
            state_d  = ST_TX_START;
          end else begin
            send_done_d = 1'b1;
            state_d     = ST_TX_HOLD;
          end
        end
      end
      ST_TX_HOLD: begin
        if (!tx_enable) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rx_count_q    <= '0;
      to_cnt_q      <= '0;
      tx_idx_q      <= '0;
      word_q        <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= '0;
      send_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_count_q    <= rx_count_d;
      to_cnt_q      <= to_cnt_d;
      tx_idx_q      <= tx_idx_d;
      word_q        <= word_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      tx_dv_q       <= tx_dv_d;
      tx_byte_q     <= tx_byte_d;
      send_done_q   <= send_done_d;
    end
  end

  assign frame_o     = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign tx_dv       = tx_dv_q;
  assign tx_byte     = tx_byte_q;
  assign send_done   = send_done_q;

endmodule

// File: tb/tb_uart_frame_link.sv
// Directed bench for uart_frame_link: one byte-repeat and one word-repeat instance.
module tb_uart_frame_link;

  localparam int unsigned FB = 76 * 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          rx_enable = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic          tx_enable = 1'b0;
  logic [31:0]   tx_word = '0;
  logic          tx_done0 = 1'b0;
  logic          tx_done1 = 1'b0;

  logic [FB-1:0] frame_o0, frame_o1;
  logic          frame_valid0, frame_valid1, frame_done0, frame_done1;
  logic          frame_abort0, frame_abort1, tx_dv0, tx_dv1, send_done0, send_done1;
  logic [7:0]    tx_byte0, tx_byte1;

  int n_checks = 0;
  int n_errors = 0;
  int cnt0 = 0, cnt1 = 0, done_n0 = 0, done_n1 = 0;
  int sd_n0 = 0, sd_n1 = 0, fd_n0 = 0, fd_n1 = 0, fa_n0 = 0, fa_n1 = 0;
  logic [7:0] cap0[$];
  logic [7:0] cap1[$];
  logic [FB-1:0] exp_frame;

  logic [7:0] exp_m0 [16] = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hBB, 8'hBB,
                              8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hDD, 8'hDD};
  logic [7:0] exp_m1 [16] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  always #5 clk = ~clk;

  uart_frame_link #(
    .RX_BYTES(76), .TX_WORD_BYTES(4), .TX_REPEAT(4), .REPEAT_MODE(0), .TIMEOUT_CYCLES(100)
  ) dut0 (
    .clk(clk), .rst_i(rst_i), .rx_enable(rx_enable), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_o(frame_o0), .frame_valid(frame_valid0), .frame_done(frame_done0),
    .frame_abort(frame_abort0), .tx_enable(tx_enable), .tx_word(tx_word), .tx_dv(tx_dv0),
    .tx_byte(tx_byte0), .tx_done(tx_done0), .send_done(send_done0)
  );

  uart_frame_link #(
    .RX_BYTES(76), .TX_WORD_BYTES(4), .TX_REPEAT(4), .REPEAT_MODE(1), .TIMEOUT_CYCLES(200_000)
  ) dut1 (
    .clk(clk), .rst_i(rst_i), .rx_enable(rx_enable), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_o(frame_o1), .frame_valid(frame_valid1), .frame_done(frame_done1),
    .frame_abort(frame_abort1), .tx_enable(tx_enable), .tx_word(tx_word), .tx_dv(tx_dv1),
    .tx_byte(tx_byte1), .tx_done(tx_done1), .send_done(send_done1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: tx_done 50 cycles after each tx_dv; pulse counters.
  always @(negedge clk) begin
    if (rst_i) begin
      cnt0 = 0; cnt1 = 0; tx_done0 = 1'b0; tx_done1 = 1'b0;
    end else begin
      tx_done0 = 1'b0;
      tx_done1 = 1'b0;
      if (tx_dv0) begin
        cap0.push_back(tx_byte0); cnt0 = 50;
      end else if (cnt0 != 0) begin
        cnt0--;
        if (cnt0 == 0) begin
          tx_done0 = 1'b1; done_n0++;
          if (cap0.size() > 0) check("tx_byte_hold0", tx_byte0, cap0[$]);
        end
      end
      if (tx_dv1) begin
        cap1.push_back(tx_byte1); cnt1 = 50;
      end else if (cnt1 != 0) begin
        cnt1--;
        if (cnt1 == 0) begin
          tx_done1 = 1'b1; done_n1++;
          if (cap1.size() > 0) check("tx_byte_hold1", tx_byte1, cap1[$]);
        end
      end
    end
    if (send_done0) sd_n0++;
    if (send_done1) sd_n1++;
    if (frame_done0) fd_n0++;
    if (frame_done1) fd_n1++;
    if (frame_abort0) fa_n0++;
    if (frame_abort1) fa_n1++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_send(input string tag);
    int w;
    w = 0;
    while ((sd_n0 == 0 || sd_n1 == 0) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check(tag, (w < 3000), 1);
  endtask

  initial begin
    int w;
    int cyc;

    repeat (3) @(negedge clk);
    check("rst_frame_o", frame_o0 == '0, 1);
    check("rst_frame_valid", frame_valid0, 0);
    check("rst_tx_dv", tx_dv0, 0);
    check("rst_tx_byte", tx_byte0, 0);
    check("rst_send_done", send_done1, 0);
    rst_i = 1'b0;

    // Full frame 0x00..0x4B with 20-cycle gaps.
    @(negedge clk);
    rx_enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 76; i++) begin
      send_byte(8'(i));
      exp_frame[8*i +: 8] = 8'(i);
      if (i == 74) check("early_frame_done", frame_done0, 0);
      if (i < 75) repeat (20) @(negedge clk);
    end
    check("frame_done0", frame_done0, 1);
    check("frame_done1", frame_done1, 1);
    check("frame_b0", frame_o0[7:0], 8'h00);
    check("frame_b75", frame_o0[607:600], 8'h4B);
    check("frame_full0", frame_o0 == exp_frame, 1);
    check("frame_full1", frame_o1 == exp_frame, 1);
    check("frame_valid0", frame_valid0, 1);
    @(negedge clk);
    check("frame_done_pulse", frame_done0, 0);

    // Partial frame then silence: dut0 discards after 100 idle cycles.
    for (int i = 0; i < 10; i++) begin
      send_byte(8'hA0 + 8'(i));
      if (i < 9) repeat (4) @(negedge clk);
    end
    cyc = 0;
    while (!frame_abort0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_latency", 64'(cyc), 100);
    check("abort_frame_kept", frame_o0 == exp_frame, 1);
    check("abort_no_done", frame_done0, 0);
    @(negedge clk);
    check("abort_pulse", frame_abort0, 0);
    check("abort1_none", frame_abort1, 0);

    // Drop the window (discards dut1's partial), then a fresh full frame.
    rx_enable = 1'b0;
    repeat (2) @(negedge clk);
    rx_enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 76; i++) begin
      send_byte(8'hFF - 8'(i));
      exp_frame[8*i +: 8] = 8'hFF - 8'(i);
      if (i < 75) repeat (3) @(negedge clk);
    end
    check("frame2_full0", frame_o0 == exp_frame, 1);
    check("frame2_full1", frame_o1 == exp_frame, 1);
    check("frame2_b0", frame_o1[7:0], 8'hFF);
    check("frame2_b75", frame_o0[607:600], 8'hB4);
    @(negedge clk);
    check("fd_count0", 64'(fd_n0), 2);
    check("fd_count1", 64'(fd_n1), 2);
    check("fa_count0", 64'(fa_n0), 1);
    check("fa_count1", 64'(fa_n1), 0);
    rx_enable = 1'b0;
    repeat (2) @(negedge clk);

    // Burst of 0xDDCCBBAA in both repeat modes.
    tx_word   = 32'hDDCCBBAA;
    tx_enable = 1'b1;
    @(negedge clk);
    check("tx_dv_lat1", tx_dv0, 0);
    @(negedge clk);
    check("tx_dv_lat2", tx_dv0, 1);
    check("tx_first0", tx_byte0, 8'hAA);
    check("tx_first1", tx_byte1, 8'hAA);
    wait_send("send_done_wait");
    @(negedge clk);
    check("burst_len0", 64'(cap0.size()), 16);
    check("burst_len1", 64'(cap1.size()), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < cap0.size()) check($sformatf("mode0_byte%0d", k), cap0[k], exp_m0[k]);
      if (k < cap1.size()) check($sformatf("mode1_byte%0d", k), cap1[k], exp_m1[k]);
    end
    repeat (5000) @(negedge clk);
    check("hold_len0", 64'(cap0.size()), 16);
    check("hold_len1", 64'(cap1.size()), 16);
    check("hold_sd0", 64'(sd_n0), 1);
    check("hold_sd1", 64'(sd_n1), 1);
    tx_enable = 1'b0;
    repeat (3) @(negedge clk);

    // Reset after the 7th byte completes.
    cap0.delete(); cap1.delete();
    sd_n0 = 0; sd_n1 = 0; done_n0 = 0;
    tx_word   = 32'h44332211;
    tx_enable = 1'b1;
    w = 0;
    while (done_n0 < 7 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    check("seven_done_wait", (w < 2000), 1);
    @(negedge clk);
    rst_i     = 1'b1;
    tx_enable = 1'b0;
    @(negedge clk);
    check("mid_rst_frame_o", frame_o0 == '0, 1);
    check("mid_rst_valid0", frame_valid0, 0);
    check("mid_rst_valid1", frame_valid1, 0);
    check("mid_rst_tx_dv", tx_dv0, 0);
    check("mid_rst_tx_byte0", tx_byte0, 0);
    check("mid_rst_tx_byte1", tx_byte1, 0);
    check("mid_rst_sent", 64'(cap0.size()), 7);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_no_sd0", 64'(sd_n0), 0);
    check("mid_rst_no_sd1", 64'(sd_n1), 0);
    cap0.delete(); cap1.delete();
    tx_enable = 1'b1;
    wait_send("resend_wait");
    @(negedge clk);
    check("resend_len", 64'(cap0.size()), 16);
    if (cap0.size() > 4) check("resend_b0", cap0[0], 8'h11);
    if (cap0.size() > 4) check("resend_b4", cap0[4], 8'h22);
    if (cap1.size() > 1) check("resend_m1_b1", cap1[1], 8'h22);
    tx_enable = 1'b0;
    repeat (3) @(negedge clk);

    // rx_enable wins when both enables rise together.
    cap0.delete(); cap1.delete();
    sd_n0 = 0; sd_n1 = 0;
    tx_word   = 32'h0D0C0B0A;
    rx_enable = 1'b1;
    tx_enable = 1'b1;
    repeat (100) @(negedge clk);
    check("prio_no_tx0", 64'(cap0.size()), 0);
    check("prio_no_tx1", 64'(cap1.size()), 0);
    rx_enable = 1'b0;
    w = 0;
    while (cap0.size() == 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("prio_tx_after_rx", (cap0.size() > 0), 1);
    wait_send("prio_send_wait");
    if (cap0.size() > 0) check("prio_b0", cap0[0], 8'h0A);
    tx_enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_frame_link.md
# uart_frame_link

Parametrised byte-stream framing engine between `uart_rx`/`uart_tx` and the mining datapath. It assembles a fixed-length inbound frame (block header without nonce) from received bytes and serialises an outbound result word with configurable redundancy. It generalises the top-level framing logic with:
- parametrised frame and word sizes
- selectable repeat modes
- an inter-byte timeout that discards partial frames
- a committed-frame buffer that never exposes partial data

## Interface
- `RX_BYTES`, default 76: inbound frame length in bytes.
- `TX_WORD_BYTES`, default 4: outbound word length in bytes.
- `TX_REPEAT`, default 4: copies of each byte (mode 0) or of the whole word (mode 1); must be ≥1.
- `REPEAT_MODE`, default 0: 0 = byte-wise repeat, 1 = word-wise repeat.
- `TIMEOUT_CYCLES`, default 200_000: idle cycles after which a partial frame is discarded; 0 disables the timeout.

One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst_i`  in  1  synchronous active-high reset.
- `rx_enable`  in  1  receive window (from `fsm` read enable).
- `rx_valid`  in  1  one-cycle byte strobe from `uart_rx`.
- `rx_byte`  in  8  received byte.
- `frame_o`  out  RX_BYTES*8  last committed frame; byte k at [8k+7:8k].
- `frame_valid`  out  1  high once any frame has committed; held until reset.
- `frame_done`  out  1  one-cycle pulse on commit.
- `frame_abort`  out  1  one-cycle pulse on timeout discard.
- `tx_enable`  in  1  transmit request (from `fsm` write enable).
- `tx_word`  in  TX_WORD_BYTES*8  word to send; byte 0 = [7:0].
- `tx_dv`  out  1  one-cycle start strobe to `uart_tx`.
- `tx_byte`  out  8  byte to `uart_tx`; stable from `tx_dv` until `tx_done`.
- `tx_done`  in  1  byte-complete pulse from `uart_tx`.
- `send_done`  out  1  one-cycle pulse after the last byte completes.

## Operation
- States: IDLE, RX, TX_START, TX_WAIT, TX_HOLD.
- IDLE:
  - `rx_enable` → RX.
  - Else `tx_enable` → TX_START; `tx_word` is snapshotted and the byte index is cleared.
  - `rx_enable` has priority when both are asserted.
- RX:
  - Each `rx_valid` writes `rx_byte` into the shadow buffer at index `rx_count`, then increments `rx_count`.
  - On storing byte RX_BYTES-1: the shadow buffer is copied to `frame_o`, `rx_count` becomes 0, `frame_done` and `frame_valid` are asserted, and the block stays in RX while `rx_enable` is high.
  - Timeout: when `rx_count`>0 and no byte arrives for TIMEOUT_CYCLES cycles, `rx_count` becomes 0 and `frame_abort` pulses. `frame_o` is unchanged.
  - `rx_enable` low → IDLE. Any partial frame is discarded silently.
- TX sequence: the total byte count is N = TX_WORD_BYTES*TX_REPEAT. For sequence index k:
  - Mode 0 sends word byte ⌊k/TX_REPEAT⌋.
  - Mode 1 sends word byte k mod TX_WORD_BYTES.
- TX_START: drive `tx_byte`, pulse `tx_dv`, then go to TX_WAIT.
- TX_WAIT, on `tx_done`:
  - If k<N-1: increment k and go to TX_START.
  - Else: pulse `send_done` and go to TX_HOLD.
- TX_HOLD: wait for `tx_enable` low, then go to IDLE. A held enable produces exactly one burst.
- `tx_enable` dropping mid-burst does not stop the burst; the current sequence completes.
- `rx_valid` is ignored in all TX states.
- Counter widths are $clog2(RX_BYTES+1), $clog2(N+1) and $clog2(TIMEOUT_CYCLES+1).

## Timing
- Reset values: `frame_o`=0, `frame_valid`=0, `frame_done`=0, `frame_abort`=0, `tx_dv`=0, `tx_byte`=0, `send_done`=0. State returns to IDLE and all counters clear.
- Reset takes effect mid-frame or mid-burst. No `send_done` or `frame_done` is produced for the aborted activity.
- `frame_done` and the updated `frame_o` appear in the cycle after the final `rx_valid`.
- First `tx_dv` appears 2 cycles after `tx_enable` is seen in IDLE (IDLE→TX_START→strobe).
- The next `tx_dv` appears 2 cycles after each `tx_done`.
- `send_done` appears in the cycle after the final `tx_done`.
- If `rx_valid` coincides with the timeout expiry cycle, the byte is accepted and the timeout does not fire.
- `tx_done` outside TX_WAIT is ignored.

## Structure
- Package `link_pkg`: state enum `link_state_t`, the mode constants `REPEAT_BYTE`=0 and `REPEAT_WORD`=1, and the default constants.
- One sub-module, `tx_byte_seq`: combinational selection of byte index k to a word byte, for either mode. The rest stays in `uart_frame_link`.

## Test plan
- Default parameters, 76 bytes 0x00..0x4B with 20-cycle gaps → `frame_done` 1 cycle after the last byte; `frame_o[7:0]`=0x00, `frame_o[607:600]`=0x4B; `frame_valid`=1.
- TIMEOUT_CYCLES=100, 10 bytes sent then silence → `frame_abort` 100 cycles after the 10th byte; `frame_o` unchanged. A following full frame commits correctly.
- Mode 0, `tx_word`=0xDDCCBBAA, uart model returns `tx_done` 50 cycles after each `tx_dv` → 16 bytes AA×4, BB×4, CC×4, DD×4, then one `send_done`.
- Mode 1, same word → AA BB CC DD repeated 4 times. Hold `tx_enable` high for 5000 cycles after `send_done` → no further `tx_dv`.
- `rst_i` asserted after the 7th transmitted byte → next cycle all outputs are at reset values; no `send_done`. The following request starts again from byte 0.
- `rx_enable` and `tx_enable` both asserted in IDLE → RX is entered and no `tx_dv` is issued until `rx_enable` drops.
